// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: frames UART bytes into {addr,data,opcode}, drives one SPI write/read, returns one response byte.
// Latency: final rx_done at cycle N -> SPI request at N+2; CMD_CHECKSUM_EN adds a 4th frame byte (addr^data^opcode).
// Backpressure: rx has no handshake; bytes arriving while busy are dropped and flagged on the sticky overrun output.
module spi_cmd_sequencer #(
    parameter logic [7:0]  OP_WRITE = 8'hA5,
    parameter logic [7:0]  OP_READ  = 8'hA1,
    parameter logic [7:0]  ACK_BYTE = 8'h06,
    parameter logic [7:0]  NAK_BYTE = 8'h15,
    parameter logic [23:0] BYTE_TMO = 24'd5_000_000,
    parameter logic [23:0] WR_WAIT  = 24'd250_000,
    parameter logic [23:0] RD_TMO   = 24'd1_000_000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       spi_write,
    output logic       spi_read,
    output logic [7:0] spi_addr,
    output logic [7:0] spi_data,
    input  logic       spi_rd_done,
    input  logic [7:0] spi_rd_data,
    output logic [7:0] tx_data,
    output logic       tx_send_en,
    input  logic       tx_done,
    output logic       overrun,
    output logic       busy
);

`ifdef CMD_CHECKSUM_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_WR,
        ST_WAIT_RD,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] tmr_q, tmr_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  op_q, op_d;
    logic [7:0]  rsp_q, rsp_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        spi_write_q, spi_write_d;
    logic        spi_read_q, spi_read_d;
    logic        tx_send_en_q, tx_send_en_d;
    logic        overrun_q, overrun_d;
    logic        chk_ok;

`ifdef CMD_CHECKSUM_EN
    logic [7:0]  chk_q, chk_d;
    assign chk_ok = (chk_q == (addr_q ^ data_q ^ op_q));
`else
    assign chk_ok = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmr_d        = tmr_q;
        addr_d       = addr_q;
        data_d       = data_q;
        op_d         = op_q;
        rsp_d        = rsp_q;
        tx_data_d    = tx_data_q;
        spi_write_d  = 1'b0;
        spi_read_d   = 1'b0;
        tx_send_en_d = 1'b0;
        overrun_d    = overrun_q;
`ifdef CMD_CHECKSUM_EN
        chk_d        = chk_q;
`endif

        if (rx_done && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (rx_done) begin
                    case (cnt_q)
                        2'd0:    addr_d = rx_data;
                        2'd1:    data_d = rx_data;
                        2'd2:    op_d   = rx_data;
`ifdef CMD_CHECKSUM_EN
                        default: chk_d  = rx_data;
`else
                        default: ;
`endif
                    endcase
                    tmr_d = '0;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d     = '0;
                        overrun_d = 1'b0;
                        state_d   = ST_ISSUE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else if (cnt_q != 2'd0) begin
                    if (tmr_q == BYTE_TMO - 24'd1) begin
                        cnt_d = '0;
                        tmr_d = '0;
                    end else begin
                        tmr_d = tmr_q + 24'd1;
                    end
                end
            end
            ST_ISSUE: begin
                // The request pulse is registered, so the wait timer starts at 1 to line up with it.
                tmr_d = 24'd1;
                if (chk_ok && (op_q == OP_WRITE)) begin
                    spi_write_d = 1'b1;
                    state_d     = ST_WAIT_WR;
                end else if (chk_ok && (op_q == OP_READ) && (data_q == 8'hFF)) begin
                    spi_read_d = 1'b1;
                    state_d    = ST_WAIT_RD;
                end else begin
                    rsp_d   = NAK_BYTE;
                    state_d = ST_SEND;
                end
            end
            ST_WAIT_WR: begin
                if (tmr_q == WR_WAIT - 24'd1) begin
                    rsp_d   = ACK_BYTE;
                    state_d = ST_SEND;
                end else begin
                    tmr_d = tmr_q + 24'd1;
                end
            end
            ST_WAIT_RD: begin
                if (spi_rd_done) begin
                    rsp_d   = spi_rd_data;
                    state_d = ST_SEND;
                end else if (tmr_q == RD_TMO - 24'd1) begin
                    rsp_d   = NAK_BYTE;
                    state_d = ST_SEND;
                end else begin
                    tmr_d = tmr_q + 24'd1;
                end
            end
            ST_SEND: begin
                tx_send_en_d = 1'b1;
                tx_data_d    = rsp_q;
                tmr_d        = '0;
                state_d      = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tmr_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            op_q         <= '0;
            rsp_q        <= '0;
            tx_data_q    <= '0;
            spi_write_q  <= 1'b0;
            spi_read_q   <= 1'b0;
            tx_send_en_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef CMD_CHECKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmr_q        <= tmr_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            op_q         <= op_d;
            rsp_q        <= rsp_d;
            tx_data_q    <= tx_data_d;
            spi_write_q  <= spi_write_d;
            spi_read_q   <= spi_read_d;
            tx_send_en_q <= tx_send_en_d;
            overrun_q    <= overrun_d;
`ifdef CMD_CHECKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    // addr/data only change while IDLE, so they are stable for the whole SPI transfer.
    assign spi_addr   = addr_q;
    assign spi_data   = data_q;
    assign spi_write  = spi_write_q;
    assign spi_read   = spi_read_q;
    assign tx_data    = tx_data_q;
    assign tx_send_en = tx_send_en_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: random and directed command frames checked against a frame-level response model.
module tb_spi_cmd_sequencer;

    localparam logic [23:0] BYTE_TMO = 24'd200;
    localparam logic [23:0] WR_WAIT  = 24'd50;
    localparam logic [23:0] RD_TMO   = 24'd100;
    localparam logic [7:0]  OP_W = 8'hA5;
    localparam logic [7:0]  OP_R = 8'hA1;
    localparam logic [7:0]  ACK  = 8'h06;
    localparam logic [7:0]  NAK  = 8'h15;
`ifdef CMD_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       spi_rd_done = 1'b0;
    logic [7:0] spi_rd_data = 8'h00;
    logic       tx_done = 1'b0;
    logic       spi_write, spi_read, tx_send_en, overrun, busy;
    logic [7:0] spi_addr, spi_data, tx_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int         wr_cyc[$];
    logic [7:0] wr_addr[$];
    logic [7:0] wr_dat[$];
    int         rd_cyc[$];
    logic [7:0] rd_addr[$];
    int         tx_cyc[$];
    logic [7:0] tx_val[$];

    int         rd_delay = -1;
    logic [7:0] rd_val = 8'h00;
    int         tx_delay = 3;
    int         rd_cnt = 0;
    int         tx_cnt = 0;

    spi_cmd_sequencer #(
        .BYTE_TMO(BYTE_TMO),
        .WR_WAIT (WR_WAIT),
        .RD_TMO  (RD_TMO)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .spi_write  (spi_write),
        .spi_read   (spi_read),
        .spi_addr   (spi_addr),
        .spi_data   (spi_data),
        .spi_rd_done(spi_rd_done),
        .spi_rd_data(spi_rd_data),
        .tx_data    (tx_data),
        .tx_send_en (tx_send_en),
        .tx_done    (tx_done),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Record every output pulse with the cycle it appeared in.
    always @(negedge Clk) begin
        if (spi_write) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(spi_addr);
            wr_dat.push_back(spi_data);
        end
        if (spi_read) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(spi_addr);
        end
        if (tx_send_en) begin
            tx_cyc.push_back(cyc);
            tx_val.push_back(tx_data);
        end
    end

    // SPI engine and UART transmitter stand-ins.
    initial forever begin
        @(posedge Clk);
        #1;
        spi_rd_done = 1'b0;
        tx_done     = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                spi_rd_done = 1'b1;
                spi_rd_data = rd_val;
            end
        end
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_done = 1'b1;
        end
        if (spi_read && rd_delay > 0) rd_cnt = rd_delay;
        if (tx_send_en) tx_cnt = tx_delay;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int model_kind(input logic [7:0] d, input logic [7:0] o, input bit chk_ok);
        if (!chk_ok) return 0;
        if (o == OP_W) return 1;
        if (o == OP_R && d == 8'hFF) return 2;
        return 0;
    endfunction

    function automatic logic [7:0] model_rsp(input int kind, input int rdly, input logic [7:0] rv);
        if (kind == 1) return ACK;
        if (kind == 2) return (rdly > 0) ? rv : NAK;
        return NAK;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, output int n);
        rx_data = b;
        rx_done = 1'b1;
        n = cyc;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic clear_q();
        wr_cyc.delete(); wr_addr.delete(); wr_dat.delete();
        rd_cyc.delete(); rd_addr.delete();
        tx_cyc.delete(); tx_val.delete();
    endtask

    task automatic do_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] o,
                            input bit bad_chk, output int n);
        logic [7:0] c;
        c = a ^ d ^ o ^ (bad_chk ? 8'h5A : 8'h00);
        send_byte(a, n);
        idle($urandom_range(0, 3));
        send_byte(d, n);
        idle($urandom_range(0, 3));
        send_byte(o, n);
        if (CHK) begin
            idle($urandom_range(0, 3));
            send_byte(c, n);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic run_cmd(input logic [7:0] a, input logic [7:0] d, input logic [7:0] o, input bit bad_chk,
                           input int rdly, input logic [7:0] rv, output int n, output bit ok);
        clear_q();
        rd_delay = rdly;
        rd_val   = rv;
        do_frame(a, d, o, bad_chk, n);
        wait_idle(ok);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        idle(3);
        checks++;
        if ({spi_write, spi_read, spi_addr, spi_data, tx_data, tx_send_en, overrun, busy} !== 28'h0)
            $display("FAIL reset_outputs: got %h required 0",
                     {spi_write, spi_read, spi_addr, spi_data, tx_data, tx_send_en, overrun, busy});
        Reset_n = 1'b1;
        idle(3);
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b0)
            $display("FAIL reset_release: busy=%b overrun=%b required 0 0", busy, overrun);
    endtask

    task automatic test_write();
        int n; bit ok;
        run_cmd(8'h12, 8'h34, OP_W, 1'b0, -1, 8'h00, n, ok);
        checks++;
        if (!ok) $display("FAIL write_done: still busy after budget");
        checks++;
        if (wr_cyc.size() != 1 || rd_cyc.size() != 0) begin
            errors++;
            $display("FAIL write_count: writes=%0d reads=%0d required 1 0", wr_cyc.size(), rd_cyc.size());
        end else if (wr_cyc[0] != n + 2 || wr_addr[0] !== 8'h12 || wr_dat[0] !== 8'h34) begin
            errors++;
            $display("FAIL write_pulse: cyc=%0d addr=%h data=%h required cyc=%0d addr=12 data=34",
                     wr_cyc[0], wr_addr[0], wr_dat[0], n + 2);
        end
        checks++;
        if (tx_val.size() != 1 || wr_cyc.size() != 1) begin
            errors++;
            $display("FAIL write_ack_count: tx=%0d required 1", tx_val.size());
        end else if (tx_val[0] !== ACK || tx_cyc[0] != wr_cyc[0] + int'(WR_WAIT)) begin
            errors++;
            $display("FAIL write_ack: data=%h cyc=%0d required 06 at cyc=%0d", tx_val[0], tx_cyc[0],
                     wr_cyc[0] + int'(WR_WAIT));
        end
        idle(5);
        checks++;
        if (tx_data !== ACK) begin
            errors++;
            $display("FAIL tx_data_hold: got %h required 06", tx_data);
        end
    endtask

    task automatic test_read();
        int n; bit ok;
        run_cmd(8'h12, 8'hFF, OP_R, 1'b0, 10, 8'h5C, n, ok);
        checks++;
        if (!ok || rd_cyc.size() != 1 || wr_cyc.size() != 0) begin
            errors++;
            $display("FAIL read_count: done=%b reads=%0d writes=%0d required 1 1 0", ok, rd_cyc.size(), wr_cyc.size());
        end else if (rd_cyc[0] != n + 2 || rd_addr[0] !== 8'h12) begin
            errors++;
            $display("FAIL read_pulse: cyc=%0d addr=%h required cyc=%0d addr=12", rd_cyc[0], rd_addr[0], n + 2);
        end
        checks++;
        if (tx_val.size() != 1 || tx_val[0] !== 8'h5C) begin
            errors++;
            $display("FAIL read_data: count=%0d data=%h required 1 5C", tx_val.size(),
                     (tx_val.size() > 0) ? tx_val[0] : 8'hxx);
        end
    endtask

    task automatic test_bad();
        logic [7:0] fr [2][3];
        int n; bit ok;
        fr[0] = '{8'h12, 8'h00, OP_R};
        fr[1] = '{8'h12, 8'h34, 8'h77};
        for (int i = 0; i < 2; i++) begin
            run_cmd(fr[i][0], fr[i][1], fr[i][2], 1'b0, 5, 8'hEE, n, ok);
            checks++;
            if (!ok || wr_cyc.size() != 0 || rd_cyc.size() != 0 || tx_val.size() != 1 || tx_val[0] !== NAK) begin
                errors++;
                $display("FAIL bad_cmd%0d: done=%b writes=%0d reads=%0d tx=%0d required 1 0 0 1 with 15",
                         i, ok, wr_cyc.size(), rd_cyc.size(), tx_val.size());
            end
        end
    endtask

    task automatic test_frame_timeout();
        int n; bit ok;
        clear_q();
        send_byte(8'h12, n);
        send_byte(8'h34, n);
        idle(250);
        run_cmd(8'h56, 8'h78, OP_W, 1'b0, -1, 8'h00, n, ok);
        checks++;
        if (!ok || wr_cyc.size() != 1 || tx_val.size() != 1) begin
            errors++;
            $display("FAIL stale_frame_count: done=%b writes=%0d tx=%0d required 1 1 1", ok, wr_cyc.size(), tx_val.size());
        end else if (wr_addr[0] !== 8'h56 || wr_dat[0] !== 8'h78 || tx_val[0] !== ACK) begin
            errors++;
            $display("FAIL stale_frame: addr=%h data=%h rsp=%h required 56 78 06", wr_addr[0], wr_dat[0], tx_val[0]);
        end
        // Gaps below the timeout must keep the frame alive even when their sum exceeds it.
        clear_q();
        send_byte(8'hAB, n);
        idle(150);
        send_byte(8'hCD, n);
        idle(150);
        send_byte(OP_W, n);
        if (CHK) begin
            idle(150);
            send_byte(8'hAB ^ 8'hCD ^ OP_W, n);
        end
        wait_idle(ok);
        checks++;
        if (!ok || wr_cyc.size() != 1 || tx_val.size() != 1) begin
            errors++;
            $display("FAIL slow_frame_count: done=%b writes=%0d tx=%0d required 1 1 1", ok, wr_cyc.size(), tx_val.size());
        end else if (wr_addr[0] !== 8'hAB || wr_dat[0] !== 8'hCD) begin
            errors++;
            $display("FAIL slow_frame: addr=%h data=%h required AB CD", wr_addr[0], wr_dat[0]);
        end
    endtask

    task automatic test_rd_timeout_overrun();
        int n, dummy; bit ok, seen;
        clear_q();
        rd_delay = -1;
        tx_delay = 20;
        do_frame(8'h12, 8'hFF, OP_R, 1'b0, n);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (tx_cyc.size() > 0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rd_timeout_seen: no response within budget");
        end
        idle(2);
        send_byte(8'h99, dummy);
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: overrun=%b busy=%b required 1 1", overrun, busy);
        end
        wait_idle(ok);
        checks++;
        if (!ok || rd_cyc.size() != 1 || tx_val.size() != 1) begin
            errors++;
            $display("FAIL rd_timeout_count: done=%b reads=%0d tx=%0d required 1 1 1", ok, rd_cyc.size(), tx_val.size());
        end else if (tx_val[0] !== NAK || tx_cyc[0] != rd_cyc[0] + int'(RD_TMO)) begin
            errors++;
            $display("FAIL rd_timeout_nak: data=%h cyc=%0d required 15 at cyc=%0d", tx_val[0], tx_cyc[0],
                     rd_cyc[0] + int'(RD_TMO));
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b required 1", overrun);
        end
        tx_delay = 3;
        run_cmd(8'h12, 8'h34, OP_W, 1'b0, -1, 8'h00, n, ok);
        checks++;
        if (!ok || overrun !== 1'b0 || wr_cyc.size() != 1) begin
            errors++;
            $display("FAIL overrun_clear: done=%b overrun=%b writes=%0d required 1 0 1", ok, overrun, wr_cyc.size());
        end else if (wr_addr[0] !== 8'h12 || wr_dat[0] !== 8'h34) begin
            errors++;
            $display("FAIL dropped_byte: addr=%h data=%h required 12 34", wr_addr[0], wr_dat[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n; bit seen;
        clear_q();
        do_frame(8'h3C, 8'hC3, OP_W, 1'b0, n);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wr_cyc.size() > 0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        idle(10);
        Reset_n = 1'b0;
        #1;
        checks++;
        if (!seen || {spi_write, spi_read, spi_addr, spi_data, tx_data, tx_send_en, overrun, busy} !== 28'h0) begin
            errors++;
            $display("FAIL reset_mid: write_seen=%b outputs=%h required 1 and 0", seen,
                     {spi_write, spi_read, spi_addr, spi_data, tx_data, tx_send_en, overrun, busy});
        end
        tick();
        Reset_n = 1'b1;
        idle(int'(WR_WAIT) + 20);
        checks++;
        if (tx_val.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_ack: tx=%0d busy=%b required 0 0", tx_val.size(), busy);
        end
    endtask

    task automatic test_random_cmds();
        logic [7:0] a, d, o, rv, exp;
        int sel, rdly, kind, n;
        bit ok, bad;
        for (int it = 0; it < 10; it++) begin
            a    = 8'($urandom);
            sel  = $urandom_range(0, 2);
            o    = (sel == 0) ? OP_W : (sel == 1) ? OP_R : 8'($urandom);
            d    = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            rdly = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(1, 80);
            rv   = 8'($urandom);
            bad  = ($urandom_range(0, 3) == 0);
            kind = model_kind(d, o, !(CHK && bad));
            exp  = model_rsp(kind, rdly, rv);
            run_cmd(a, d, o, bad, rdly, rv, n, ok);
            checks++;
            if (!ok || wr_cyc.size() != ((kind == 1) ? 1 : 0) || rd_cyc.size() != ((kind == 2) ? 1 : 0)) begin
                errors++;
                $display("FAIL rand%0d_kind: done=%b writes=%0d reads=%0d required kind %0d", it, ok,
                         wr_cyc.size(), rd_cyc.size(), kind);
            end
            checks++;
            if (tx_val.size() != 1 || tx_val[0] !== exp) begin
                errors++;
                $display("FAIL rand%0d_rsp: count=%0d data=%h required 1 %h", it, tx_val.size(),
                         (tx_val.size() > 0) ? tx_val[0] : 8'hxx, exp);
            end
            if (kind == 1 && wr_cyc.size() == 1 && tx_cyc.size() == 1) begin
                checks++;
                if (wr_cyc[0] != n + 2 || wr_addr[0] !== a || wr_dat[0] !== d ||
                    tx_cyc[0] != wr_cyc[0] + int'(WR_WAIT)) begin
                    errors++;
                    $display("FAIL rand%0d_write: cyc=%0d addr=%h data=%h ack_cyc=%0d required %0d %h %h %0d", it,
                             wr_cyc[0], wr_addr[0], wr_dat[0], tx_cyc[0], n + 2, a, d, n + 2 + int'(WR_WAIT));
                end
            end
            if (kind == 2 && rd_cyc.size() == 1 && tx_cyc.size() == 1) begin
                checks++;
                if (rd_cyc[0] != n + 2 || rd_addr[0] !== a ||
                    (rdly < 0 && tx_cyc[0] != rd_cyc[0] + int'(RD_TMO)) ||
                    (rdly > 0 && (tx_cyc[0] <= rd_cyc[0] + rdly || tx_cyc[0] > rd_cyc[0] + rdly + 3))) begin
                    errors++;
                    $display("FAIL rand%0d_read: cyc=%0d addr=%h rsp_cyc=%0d required cyc=%0d addr=%h delay=%0d", it,
                             rd_cyc[0], rd_addr[0], tx_cyc[0], n + 2, a, rdly);
                end
            end
            idle($urandom_range(0, 4));
        end
    endtask

`ifdef CMD_CHECKSUM_EN
    task automatic test_checksum();
        int n; bit ok;
        run_cmd(8'h12, 8'h34, OP_W, 1'b0, -1, 8'h00, n, ok);
        checks++;
        if (!ok || wr_cyc.size() != 1 || tx_val.size() != 1 || tx_val[0] !== ACK) begin
            errors++;
            $display("FAIL checksum_good: done=%b writes=%0d tx=%0d required 1 1 1 with 06", ok, wr_cyc.size(), tx_val.size());
        end
        run_cmd(8'h12, 8'h34, OP_W, 1'b1, -1, 8'h00, n, ok);
        checks++;
        if (!ok || wr_cyc.size() != 0 || tx_val.size() != 1 || tx_val[0] !== NAK) begin
            errors++;
            $display("FAIL checksum_bad: done=%b writes=%0d tx=%0d required 1 0 1 with 15", ok, wr_cyc.size(), tx_val.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad();
        test_frame_timeout();
        test_rd_timeout_overrun();
        test_reset_mid();
`ifdef CMD_CHECKSUM_EN
        test_checksum();
`endif
        test_random_cmds();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
